// File: rtl/conv_layer_address_gen_if.sv
// conv_layer_address_gen_if: controller/memory-side bundle; start,stall into the sequencer; st, w_addr/w_valid, in_addr/in_valid/last_tap, out_row/out_col, done out of it
interface conv_layer_address_gen_if #(
  parameter int W_AW  = 8,
  parameter int IN_AW = 10
);
  logic             start;
  logic             stall;
  logic [3:0]       st;
  logic [W_AW-1:0]  w_addr;
  logic             w_valid;
  logic [IN_AW-1:0] in_addr;
  logic             in_valid;
  logic             last_tap;
  logic [4:0]       out_row;
  logic [4:0]       out_col;
  logic             done;
  modport master (output start, stall, input st, w_addr, w_valid, in_addr, in_valid, last_tap, out_row, out_col, done);
  modport slave  (input start, stall, output st, w_addr, w_valid, in_addr, in_valid, last_tap, out_row, out_col, done);
endinterface

// File: rtl/conv_layer_address_gen.sv
// conv_layer_address_gen: conv-layer weight/input address sequencer; ports clk, rst, bus (slave: start/stall in; st, w_addr/w_valid, in_addr/in_valid/last_tap, out_row/out_col, done out)
module conv_layer_address_gen #(
  parameter int IN_W   = 32,
  parameter int IN_H   = 32,
  parameter int IN_CH  = 1,
  parameter int K      = 5,
  parameter int STRIDE = 1,
  parameter int IN_AW  = 10,
  parameter int W_AW   = 8
) (
  input logic clk,
  input logic rst,
  conv_layer_address_gen_if.slave bus
);
  localparam int W_WORDS = K*K*IN_CH+1;
  localparam int OUT_W = (IN_W-K)/STRIDE+1;
  localparam int OUT_H = (IN_H-K)/STRIDE+1;
  localparam logic [3:0] IDLE = 4'b0001, LOAD_W = 4'b0010, CALC = 4'b0100, DONE = 4'b1000;
  localparam logic [W_AW-1:0] W_LAST = W_AW'(W_WORDS-1);
  localparam logic [7:0] KM1 = 8'(K-1), CHM1 = 8'(IN_CH-1);
  localparam logic [4:0] OWM1 = 5'(OUT_W-1), OHM1 = 5'(OUT_H-1);
  localparam logic [IN_AW-1:0] ROW_STEP = IN_AW'(IN_W-K+1);
  localparam logic [IN_AW-1:0] CH_STEP = IN_AW'(IN_H*IN_W-(K-1)*IN_W-K+1);
  localparam logic [IN_AW-1:0] PIX_STEP = IN_AW'(STRIDE);
  localparam logic [IN_AW-1:0] ROW_PIX = IN_AW'(STRIDE*IN_W);
  logic [3:0] st_q, st_d;
  logic [W_AW-1:0] w_addr_q, w_addr_d;
  logic w_valid_q, w_valid_d, in_valid_q, in_valid_d, last_q, last_d, done_q, done_d;
  logic [IN_AW-1:0] in_addr_q, in_addr_d, off_q, off_d, row_q, row_d, pix_q, pix_d;
  logic [7:0] kx_q, kx_d, ky_q, ky_d, c_q, c_d;
  logic [4:0] ox_q, ox_d, oy_q, oy_d;
  logic kx_end, ky_end, c_end, ox_end, oy_end, tap_end, pix_end, all_end, step;
  assign kx_end  = kx_q == KM1;
  assign ky_end  = ky_q == KM1;
  assign c_end   = c_q == CHM1;
  assign ox_end  = ox_q == OWM1;
  assign oy_end  = oy_q == OHM1;
  assign tap_end = kx_end && ky_end && c_end;
  assign pix_end = tap_end && ox_end;
  assign all_end = pix_end && oy_end;
  assign step    = st_q == CALC && st_d == CALC && !bus.stall;
  always_ff @(posedge clk)
    st_q <= rst ? IDLE : st_d;
  always_comb
    st_d = (st_q == IDLE && bus.start) ? LOAD_W :
           (st_q == LOAD_W && !bus.stall && w_addr_q == W_LAST) ? CALC :
           (st_q == CALC && !bus.stall && all_end) ? DONE :
           (st_q == DONE) ? IDLE : st_q;
  // off tracks the tap offset within the current window; pix/row track the window origin,
  // so every address is one add of two incrementally maintained terms.
  always_comb begin
    w_valid_d  = st_d == LOAD_W;
    w_addr_d   = (st_q == LOAD_W && st_d == LOAD_W && !bus.stall) ? w_addr_q + 1'b1 :
                 (st_d == LOAD_W) ? w_addr_q : '0;
    in_valid_d = st_d == CALC;
    done_d     = st_d == DONE;
    kx_d  = st_d == CALC ? kx_q : '0;
    ky_d  = st_d == CALC ? ky_q : '0;
    c_d   = st_d == CALC ? c_q : '0;
    ox_d  = st_d == CALC ? ox_q : '0;
    oy_d  = st_d == CALC ? oy_q : '0;
    off_d = st_d == CALC ? off_q : '0;
    row_d = st_d == CALC ? row_q : '0;
    pix_d = st_d == CALC ? pix_q : '0;
    if (step) begin
      kx_d  = kx_end ? 8'd0 : kx_q + 8'd1;
      ky_d  = kx_end ? (ky_end ? 8'd0 : ky_q + 8'd1) : ky_q;
      c_d   = (kx_end && ky_end) ? (c_end ? 8'd0 : c_q + 8'd1) : c_q;
      off_d = tap_end ? '0 : (kx_end && ky_end) ? off_q + CH_STEP : kx_end ? off_q + ROW_STEP : off_q + 1'b1;
      ox_d  = tap_end ? (ox_end ? 5'd0 : ox_q + 5'd1) : ox_q;
      oy_d  = pix_end ? oy_q + 5'd1 : oy_q;
      row_d = pix_end ? row_q + ROW_PIX : row_q;
      pix_d = pix_end ? row_d : tap_end ? pix_q + PIX_STEP : pix_q;
    end
    in_addr_d = pix_d + off_d;
    last_d    = st_d == CALC && kx_d == KM1 && ky_d == KM1 && c_d == CHM1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      w_addr_q   <= '0;
      w_valid_q  <= 1'b0;
      in_addr_q  <= '0;
      in_valid_q <= 1'b0;
      last_q     <= 1'b0;
      done_q     <= 1'b0;
      kx_q       <= '0;
      ky_q       <= '0;
      c_q        <= '0;
      ox_q       <= '0;
      oy_q       <= '0;
      off_q      <= '0;
      row_q      <= '0;
      pix_q      <= '0;
    end else begin
      w_addr_q   <= w_addr_d;
      w_valid_q  <= w_valid_d;
      in_addr_q  <= in_addr_d;
      in_valid_q <= in_valid_d;
      last_q     <= last_d;
      done_q     <= done_d;
      kx_q       <= kx_d;
      ky_q       <= ky_d;
      c_q        <= c_d;
      ox_q       <= ox_d;
      oy_q       <= oy_d;
      off_q      <= off_d;
      row_q      <= row_d;
      pix_q      <= pix_d;
    end
  end
  assign bus.st       = st_q;
  assign bus.w_addr   = w_addr_q;
  assign bus.w_valid  = w_valid_q;
  assign bus.in_addr  = in_addr_q;
  assign bus.in_valid = in_valid_q;
  assign bus.last_tap = last_q;
  assign bus.out_row  = oy_q;
  assign bus.out_col  = ox_q;
  assign bus.done     = done_q;
endmodule

// File: tb/tb_conv_layer_address_gen.sv
// tb_conv_layer_address_gen: checks three sequencer configurations against a beat-index model
module tb_conv_layer_address_gen;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  conv_layer_address_gen_if #(.W_AW(8), .IN_AW(10)) ia();
  conv_layer_address_gen_if #(.W_AW(8), .IN_AW(11)) ib();
  conv_layer_address_gen_if #(.W_AW(5), .IN_AW(8))  ic();
  conv_layer_address_gen #(.IN_W(32), .IN_H(32), .IN_CH(1), .K(5), .STRIDE(1), .IN_AW(10), .W_AW(8))
    ua (.clk(clk), .rst(rst), .bus(ia.slave));
  conv_layer_address_gen #(.IN_W(14), .IN_H(14), .IN_CH(6), .K(5), .STRIDE(1), .IN_AW(11), .W_AW(8))
    ub (.clk(clk), .rst(rst), .bus(ib.slave));
  conv_layer_address_gen #(.IN_W(12), .IN_H(12), .IN_CH(1), .K(4), .STRIDE(2), .IN_AW(8), .W_AW(5))
    uc (.clk(clk), .rst(rst), .bus(ic.slave));
  int cw[3] = '{32, 14, 12};
  int chh[3] = '{32, 14, 12};
  int cc[3] = '{1, 6, 1};
  int ck[3] = '{5, 5, 4};
  int cs[3] = '{1, 1, 2};
  int n_m[3] = '{-1, -1, -1};
  int last_addr[3] = '{0, 0, 0};
  int checks = 0;
  int errors = 0;
  bit en = 1'b0;
  int cap_addr[$];
  int cap_lt[$];
  function automatic void sizes(input int i, output int ww, output int tt);
    int ow, oh;
    ow = (cw[i]-ck[i])/cs[i]+1;
    oh = (chh[i]-ck[i])/cs[i]+1;
    ww = ck[i]*ck[i]*cc[i]+1;
    tt = ow*oh*ck[i]*ck[i]*cc[i];
  endfunction
  // n is the count of beats since the first LOAD_W cycle; -1 means idle.
  function automatic void model(input int i, input int n, output int est, output int ewa, output int ewv,
                                output int eia, output int eiv, output int elt, output int er, output int ec, output int ed);
    int ww, tt, tp, ow, t, p, r, kx, ky, c;
    sizes(i, ww, tt);
    tp = ck[i]*ck[i]*cc[i];
    ow = (cw[i]-ck[i])/cs[i]+1;
    est = 1; ewa = 0; ewv = 0; eia = 0; eiv = 0; elt = 0; er = 0; ec = 0; ed = 0;
    if (n < 0) begin
    end else if (n < ww) begin
      est = 2; ewa = n; ewv = 1;
    end else if (n < ww+tt) begin
      t = n-ww; p = t/tp; r = t%tp;
      kx = r%ck[i]; ky = (r/ck[i])%ck[i]; c = r/(ck[i]*ck[i]);
      ec = p%ow; er = p/ow;
      eia = c*chh[i]*cw[i] + (er*cs[i]+ky)*cw[i] + ec*cs[i]+kx;
      est = 4; eiv = 1; elt = (r == tp-1) ? 1 : 0;
    end else begin
      est = 8; ed = 1;
    end
  endfunction
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors <= 20) $display("FAIL %s got %0d want %0d", nm, act, exp);
    end
  endtask
  task automatic cmp(input int i, input int st, input int wa, input int wv, input int ad, input int iv,
                     input int lt, input int r, input int c, input int d);
    int est, ewa, ewv, eia, eiv, elt, er, ec, ed;
    model(i, n_m[i], est, ewa, ewv, eia, eiv, elt, er, ec, ed);
    chk($sformatf("d%0d st", i), st, est);
    chk($sformatf("d%0d w_valid", i), wv, ewv);
    chk($sformatf("d%0d in_valid", i), iv, eiv);
    chk($sformatf("d%0d done", i), d, ed);
    if (est == 1 || ewv == 1) chk($sformatf("d%0d w_addr", i), wa, ewa);
    if (est == 1 || eiv == 1) begin
      chk($sformatf("d%0d in_addr", i), ad, eia);
      chk($sformatf("d%0d last_tap", i), lt, elt);
      chk($sformatf("d%0d out_row", i), r, er);
      chk($sformatf("d%0d out_col", i), c, ec);
    end
    if (iv == 1) last_addr[i] = ad;
  endtask
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      int ww, tt;
      logic s_start, s_stall;
      sizes(i, ww, tt);
      s_start = (i == 0) ? ia.start : (i == 1) ? ib.start : ic.start;
      s_stall = (i == 0) ? ia.stall : (i == 1) ? ib.stall : ic.stall;
      if (rst) n_m[i] <= -1;
      else if (n_m[i] < 0) n_m[i] <= s_start ? 0 : -1;
      else if (n_m[i] == ww+tt) n_m[i] <= -1;
      else if (!s_stall) n_m[i] <= n_m[i] + 1;
    end
  end
  always @(negedge clk) if (en) begin
    cmp(0, int'(ia.st), int'(ia.w_addr), int'(ia.w_valid), int'(ia.in_addr), int'(ia.in_valid),
        int'(ia.last_tap), int'(ia.out_row), int'(ia.out_col), int'(ia.done));
    cmp(1, int'(ib.st), int'(ib.w_addr), int'(ib.w_valid), int'(ib.in_addr), int'(ib.in_valid),
        int'(ib.last_tap), int'(ib.out_row), int'(ib.out_col), int'(ib.done));
    cmp(2, int'(ic.st), int'(ic.w_addr), int'(ic.w_valid), int'(ic.in_addr), int'(ic.in_valid),
        int'(ic.last_tap), int'(ic.out_row), int'(ic.out_col), int'(ic.done));
    if (ia.in_valid && cap_addr.size() < 26) begin
      cap_addr.push_back(int'(ia.in_addr));
      cap_lt.push_back(int'(ia.last_tap));
    end
  end
  initial begin
    int est, ewa, ewv, eia, eiv, elt, er, ec, ed, cyc, cb, dn, s;
    bit db, dc;
    ia.start = 0; ia.stall = 0; ib.start = 0; ib.stall = 0; ic.start = 0; ic.stall = 0;
    repeat (3) @(negedge clk);
    rst = 0;
    en = 1;
    model(0, 25, est, ewa, ewv, eia, eiv, elt, er, ec, ed);        chk("pin A last w_addr", ewa, 25);
    model(0, 26, est, ewa, ewv, eia, eiv, elt, er, ec, ed);        chk("pin A first tap", eia, 0);
    model(0, 26+24, est, ewa, ewv, eia, eiv, elt, er, ec, ed);     chk("pin A tap 24", eia, 132); chk("pin A lt 24", elt, 1);
    model(0, 26+25, est, ewa, ewv, eia, eiv, elt, er, ec, ed);     chk("pin A pix01", eia, 1);
    model(0, 26+19599, est, ewa, ewv, eia, eiv, elt, er, ec, ed);  chk("pin A final", eia, 1023); chk("pin A row", er, 27);
    model(0, 26+19600, est, ewa, ewv, eia, eiv, elt, er, ec, ed);  chk("pin A done", ed, 1);
    model(1, 151+25, est, ewa, ewv, eia, eiv, elt, er, ec, ed);    chk("pin B ch1", eia, 196);
    model(1, 151+14999, est, ewa, ewv, eia, eiv, elt, er, ec, ed); chk("pin B final", eia, 1175);
    model(2, 17+16, est, ewa, ewv, eia, eiv, elt, er, ec, ed);     chk("pin C pix01", eia, 2);
    model(2, 17+80, est, ewa, ewv, eia, eiv, elt, er, ec, ed);     chk("pin C pix10", eia, 24);
    chk("reset st", int'(ia.st), 1);
    ia.start = 1;
    @(negedge clk);
    ia.start = 0;
    cyc = 0;
    while (!ia.done && cyc < 20000) begin @(negedge clk); cyc++; end
    chk("A done latency", cyc, 19626);
    chk("A final in_addr", last_addr[0], 1023);
    chk("A cap size", cap_addr.size(), 26);
    if (cap_addr.size() == 26) begin
      chk("A cap0", cap_addr[0], 0);
      chk("A cap4", cap_addr[4], 4);
      chk("A cap5", cap_addr[5], 32);
      chk("A cap24", cap_addr[24], 132);
      chk("A cap25 pix01", cap_addr[25], 1);
      s = 0;
      for (int j = 0; j < 24; j++) s += cap_lt[j];
      chk("A early last_tap", s, 0);
      chk("A last_tap 132", cap_lt[24], 1);
    end
    ia.start = 1;
    @(negedge clk);
    ia.start = 0;
    chk("start in DONE st", int'(ia.st), 1);
    @(negedge clk);
    chk("start in DONE not queued", int'(ia.st), 1);
    ia.start = 1;
    @(negedge clk);
    @(negedge clk);
    ia.start = 0;
    cyc = 0;
    while (!(ia.in_valid && ia.in_addr == 34) && cyc < 200) begin @(negedge clk); cyc++; end
    chk("reach 34", int'(ia.in_addr), 34);
    ia.stall = 1;
    repeat (3) begin
      @(negedge clk);
      chk("stall addr", int'(ia.in_addr), 34);
      chk("stall valid", int'(ia.in_valid), 1);
      chk("stall last_tap", int'(ia.last_tap), 0);
    end
    ia.stall = 0;
    @(negedge clk);
    chk("resume addr", int'(ia.in_addr), 35);
    @(negedge clk);
    chk("resume next", int'(ia.in_addr), 36);
    cyc = 0;
    while (!(ia.in_valid && ia.out_row == 5 && ia.out_col == 7) && cyc < 5000) begin @(negedge clk); cyc++; end
    chk("reach pixel 5,7", int'(ia.out_col), 7);
    rst = 1;
    @(negedge clk);
    chk("rst st", int'(ia.st), 1);
    chk("rst in_valid", int'(ia.in_valid), 0);
    chk("rst in_addr", int'(ia.in_addr), 0);
    rst = 0;
    dn = 0;
    repeat (40) begin @(negedge clk); dn += int'(ia.done); end
    chk("no done after rst", dn, 0);
    ia.start = 1;
    @(negedge clk);
    ia.start = 0;
    chk("restart w_addr", int'(ia.w_addr), 0);
    chk("restart w_valid", int'(ia.w_valid), 1);
    @(negedge clk);
    chk("restart w_addr1", int'(ia.w_addr), 1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    ib.start = 1; ic.start = 1;
    @(negedge clk);
    ib.start = 0; ic.start = 0;
    cyc = 0; cb = -1; db = 0; dc = 0;
    while (!(db && dc) && cyc < 16000) begin
      @(negedge clk);
      cyc++;
      if (ib.done && !db) cb = cyc;
      if (ib.done) db = 1;
      if (ic.done) dc = 1;
      ic.stall = ($urandom_range(0, 3) == 0);
    end
    ic.stall = 0;
    chk("B done seen", int'(db), 1);
    chk("C done seen", int'(dc), 1);
    chk("B done latency", cb, 15151);
    chk("B final in_addr", last_addr[1], 1175);
    chk("C final in_addr", last_addr[2], 143);
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
